// File: rtl/cgra_seq_pkg.sv
// Shared types, constants and PC arithmetic for the CGRA program sequencer.
package cgra_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        VWAIT = 3'd3,
        HALT  = 3'd4
    } seq_state_t;

    // Next-pc selection driven by the sequencer FSM.
    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_INC    = 2'd1,
        PC_BRANCH = 2'd2,
        PC_CLEAR  = 2'd3
    } pc_sel_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // branch_imm holds B-imm[12:1], i.e. a signed half-word offset. The PC counts
    // 32-bit words, so the word offset is branch_imm >>> 1 (arithmetic). The sum is
    // returned at full width; callers truncate to their PC width, which gives the
    // modulo-2^AW wrap in both directions.
    function automatic logic [31:0] pc_branch(input logic [31:0] pc, input logic [11:0] imm);
        logic signed [31:0] off_s;
        off_s = {{20{imm[11]}}, imm};
        off_s = off_s >>> 1;
        return pc + $unsigned(off_s);
    endfunction

endpackage

// File: rtl/cgra_instr_sequencer_pc_unit.sv
// Program counter register with its next-pc mux (hold / +1 / branch / clear).
module seq_pc_unit
    import cgra_seq_pkg::*;
#(
    parameter int IMEM_AW = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  pc_sel_t            pc_sel,
    input  logic [11:0]        branch_imm,
    output logic [IMEM_AW-1:0] pc,
    output logic [IMEM_AW-1:0] pc_next
);

    logic [IMEM_AW-1:0] pc_r;
    logic               pc_en_s;

    // Next-pc selection; also exported so the fetch address leads the register.
    always_comb begin
        pc_next = pc_r;
        case (pc_sel)
            PC_HOLD:   pc_next = pc_r;
            PC_INC:    pc_next = pc_r + {{(IMEM_AW-1){1'b0}}, 1'b1};
            PC_BRANCH: pc_next = IMEM_AW'(pc_branch(32'(pc_r), branch_imm));
            PC_CLEAR:  pc_next = '0;
            default:   pc_next = pc_r;
        endcase
    end

    assign pc_en_s = (pc_sel != PC_HOLD);

    // Enabled PC register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= '0;
        end else if (pc_en_s) begin
            pc_r <= pc_next;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/cgra_instr_sequencer.sv
// CGRA program sequencer: fetches instruction words, presents them one at a time
// to the decoder, stalls on vector ops, resolves bne and stops on wfi.
module cgra_instr_sequencer
    import cgra_seq_pkg::*;
#(
    parameter int IMEM_AW     = 8,
    parameter int DWIDTH_INST = 32,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ap_start,
    output logic                   imem_en,
    output logic [IMEM_AW-1:0]     imem_addr,
    input  logic [DWIDTH_INST-1:0] imem_rdata,
    output logic [DWIDTH_INST-1:0] instr,
    output logic                   instr_valid,
    input  logic                   is_not_vect,
    input  logic                   is_bne,
    input  logic                   branch_taken,
    input  logic [11:0]            branch_imm,
    input  logic                   dec_ap_done,
    input  logic                   vec_done,
    output logic                   busy,
    output logic                   ap_done,
    output logic [IMEM_AW-1:0]     pc,
    output logic [CNT_W-1:0]       instr_count,
    output logic [CNT_W-1:0]       stall_count
);

    seq_state_t             state_r;
    seq_state_t             state_next_s;
    pc_sel_t                pc_sel_s;
    logic                   imem_en_s;
    logic [IMEM_AW-1:0]     pc_next_s;
    logic [DWIDTH_INST-1:0] instr_r;
    logic                   instr_valid_r;
    logic                   busy_r;
    logic                   ap_done_r;
    logic [CNT_W-1:0]       instr_cnt_r;
    logic [CNT_W-1:0]       stall_cnt_r;

    seq_pc_unit #(
        .IMEM_AW (IMEM_AW)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .pc_sel     (pc_sel_s),
        .branch_imm (branch_imm),
        .pc         (pc),
        .pc_next    (pc_next_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state, pc selection and memory read request. The read is issued in the
    // cycle that leaves for FETCH so the word is on imem_rdata during FETCH.
    always_comb begin
        state_next_s = state_r;
        pc_sel_s     = PC_HOLD;
        imem_en_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (ap_start) begin
                    pc_sel_s     = PC_CLEAR;
                    imem_en_s    = 1'b1;
                    state_next_s = FETCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FETCH: begin
                state_next_s = ISSUE;
            end
            ISSUE: begin
                if (dec_ap_done) begin
                    state_next_s = HALT;
                end else if (!is_not_vect) begin
                    pc_sel_s = PC_INC;
                    if (vec_done) begin
                        imem_en_s    = 1'b1;
                        state_next_s = FETCH;
                    end else begin
                        state_next_s = VWAIT;
                    end
                end else if (is_bne && branch_taken) begin
                    pc_sel_s     = PC_BRANCH;
                    imem_en_s    = 1'b1;
                    state_next_s = FETCH;
                end else begin
                    pc_sel_s     = PC_INC;
                    imem_en_s    = 1'b1;
                    state_next_s = FETCH;
                end
            end
            VWAIT: begin
                if (vec_done) begin
                    imem_en_s    = 1'b1;
                    state_next_s = FETCH;
                end else begin
                    state_next_s = VWAIT;
                end
            end
            HALT: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Registered decoder-facing outputs: instr holds the fetched word only while issuing.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_r       <= DWIDTH_INST'(NOP_INSTR);
            instr_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            ap_done_r     <= 1'b0;
        end else begin
            instr_r       <= (state_r == FETCH) ? imem_rdata : DWIDTH_INST'(NOP_INSTR);
            instr_valid_r <= (state_next_s == ISSUE);
            busy_r        <= (state_next_s != IDLE);
            ap_done_r     <= (state_r == HALT);
        end
    end

    // Saturating performance counters, cleared only by reset or an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_cnt_r <= '0;
            stall_cnt_r <= '0;
        end else if ((state_r == IDLE) && ap_start) begin
            instr_cnt_r <= '0;
            stall_cnt_r <= '0;
        end else begin
            if ((state_r == ISSUE) && !(&instr_cnt_r)) begin
                instr_cnt_r <= instr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if ((state_r == VWAIT) && !(&stall_cnt_r)) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign imem_en     = imem_en_s;
    assign imem_addr   = pc_next_s;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign busy        = busy_r;
    assign ap_done     = ap_done_r;
    assign instr_count = instr_cnt_r;
    assign stall_count = stall_cnt_r;

endmodule

// File: tb/tb_cgra_instr_sequencer.sv
// Directed self-checking bench for cgra_instr_sequencer with an issue scoreboard.
module tb_cgra_instr_sequencer;

    localparam int AW = 8;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] WFI   = 32'h1050_0073;
    localparam logic [31:0] ADDI1 = 32'h0010_0093;
    localparam logic [31:0] ADDI2 = 32'h0020_0113;
    localparam logic [31:0] ADDI3 = 32'h0030_0193;
    localparam logic [31:0] ADDI4 = 32'h0040_0213;
    localparam logic [31:0] VMACC = 32'hB620_2057;

    logic          clk = 1'b0;
    logic          rst;
    logic          ap_start;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          is_not_vect;
    logic          is_bne;
    logic          branch_taken;
    logic [11:0]   branch_imm;
    logic          dec_ap_done;
    logic          vec_done;
    logic          busy;
    logic          ap_done;
    logic [AW-1:0] pc;
    logic [31:0]   instr_count;
    logic [31:0]   stall_count;

    logic [31:0]   imem [0:(1<<AW)-1];
    logic [39:0]   exp_q [$];
    int            total  = 0;
    int            passed = 0;
    int            fails  = 0;
    int            bne_hits = 0;
    int            taken_limit = 0;

    cgra_instr_sequencer #(.IMEM_AW(AW), .DWIDTH_INST(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .ap_start(ap_start), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .is_not_vect(is_not_vect), .is_bne(is_bne), .branch_taken(branch_taken),
        .branch_imm(branch_imm), .dec_ap_done(dec_ap_done), .vec_done(vec_done),
        .busy(busy), .ap_done(ap_done), .pc(pc), .instr_count(instr_count),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory, one cycle read latency.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem[imem_addr];
    end

    // Minimal decoder model: opcode 0x57 is vector, bne is opcode 0x63 funct3 001.
    assign is_not_vect  = (instr[6:0] != 7'h57);
    assign is_bne       = (instr[6:0] == 7'h63) && (instr[14:12] == 3'b001);
    assign branch_imm   = {instr[31], instr[7], instr[30:25], instr[11:8]};
    assign dec_ap_done  = instr_valid && (instr == WFI);
    assign branch_taken = is_bne && (bne_hits < taken_limit);

    // Count issued bne instructions so each test can allow exactly one taken branch.
    always @(posedge clk) begin
        if (instr_valid && is_bne) bne_hits <= bne_hits + 1;
    end

    // bne x1,x2 with B-imm[12:1] = b.
    function automatic logic [31:0] enc_bne(input logic [11:0] b);
        return {b[11], b[9:4], 5'd2, 5'd1, 3'b001, b[3:0], b[10], 7'h63};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] p, input logic [31:0] w);
        exp_q.push_back({p, w});
    endtask

    // Scoreboard: every issued instruction must match the next expected (pc, word).
    always @(negedge clk) begin
        logic [39:0] e;
        if (instr_valid) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("issue_pc", 32'(pc), 32'(e[39:32]));
                check("issue_instr", instr, e[31:0]);
            end
        end
    end

    task automatic start();
        @(negedge clk); ap_start = 1'b1;
        @(negedge clk); ap_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!ap_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(ap_done), 32'd1);
    endtask

    initial begin
        rst = 1'b1; ap_start = 1'b0; vec_done = 1'b0;
        for (int i = 0; i < (1 << AW); i++) imem[i] = NOP;
        repeat (3) @(negedge clk);
        // Reset state.
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_done", 32'(ap_done), 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_icnt", instr_count, 32'd0);
        check("rst_scnt", stall_count, 32'd0);
        check("rst_imem_en", 32'(imem_en), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: straight line, with an ap_start pulse mid-run that must be ignored.
        imem[0] = ADDI1; imem[1] = ADDI2; imem[2] = WFI;
        push(8'd0, ADDI1); push(8'd1, ADDI2); push(8'd2, WFI);
        ap_start = 1'b1; #1;
        check("t1_start_en", 32'(imem_en), 32'd1);
        check("t1_start_addr", 32'(imem_addr), 32'd0);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            ap_start = (c == 4);
            check($sformatf("t1_valid_c%0d", c), 32'(instr_valid), 32'((c == 2) || (c == 4) || (c == 6)));
            check($sformatf("t1_done_c%0d", c), 32'(ap_done), 32'(c == 8));
            check($sformatf("t1_busy_c%0d", c), 32'(busy), 32'((c >= 1) && (c <= 7)));
        end
        check("t1_icnt", instr_count, 32'd3);
        check("t1_pc", 32'(pc), 32'd2);
        check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // 2: vector stall of five VWAIT cycles; a vec_done during FETCH is ignored.
        imem[0] = ADDI1; imem[1] = VMACC; imem[2] = WFI;
        push(8'd0, ADDI1); push(8'd1, VMACC); push(8'd2, WFI);
        start();
        @(negedge clk);                                   // cycle 2: ISSUE addi
        check("t2_valid_c2", 32'(instr_valid), 32'd1);
        @(negedge clk); vec_done = 1'b1;                  // cycle 3: FETCH
        @(negedge clk); vec_done = 1'b0;                  // cycle 4: ISSUE vmacc
        check("t2_valid_c4", 32'(instr_valid), 32'd1);
        repeat (3) @(negedge clk);                        // cycle 7: VWAIT
        check("t2_vwait_valid", 32'(instr_valid), 32'd0);
        check("t2_vwait_busy", 32'(busy), 32'd1);
        check("t2_vwait_en", 32'(imem_en), 32'd0);
        repeat (2) @(negedge clk);                        // cycle 9: last VWAIT
        vec_done = 1'b1; #1;
        check("t2_resume_en", 32'(imem_en), 32'd1);
        check("t2_resume_addr", 32'(imem_addr), 32'd2);
        @(negedge clk); vec_done = 1'b0;                  // cycle 10: FETCH
        check("t2_scnt", stall_count, 32'd5);
        check("t2_pc", 32'(pc), 32'd2);
        check("t2_fetch_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);                                   // cycle 11: ISSUE wfi
        check("t2_valid_c11", 32'(instr_valid), 32'd1);
        wait_done("t2_done", 10);
        check("t2_icnt", instr_count, 32'd3);
        check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // 3: bne at pc 4 with -8 bytes, taken once (to 2) then not taken (to 5).
        imem[0] = ADDI1; imem[1] = ADDI2; imem[2] = ADDI3; imem[3] = ADDI4;
        imem[4] = enc_bne(12'hFFC); imem[5] = WFI;
        taken_limit = bne_hits + 1;
        push(8'd0, ADDI1); push(8'd1, ADDI2); push(8'd2, ADDI3); push(8'd3, ADDI4);
        push(8'd4, enc_bne(12'hFFC)); push(8'd2, ADDI3); push(8'd3, ADDI4);
        push(8'd4, enc_bne(12'hFFC)); push(8'd5, WFI);
        start();
        wait_done("t3_done", 60);
        check("t3_icnt", instr_count, 32'd9);
        check("t3_scnt", stall_count, 32'd0);
        check("t3_pc", 32'(pc), 32'd5);
        check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // 4: wrap both ways: 0x01 - 2 words -> 0xFF, 0xFF + 1 -> 0x00.
        imem[0] = ADDI1; imem[1] = enc_bne(12'hFFC); imem[255] = ADDI2; imem[2] = WFI;
        taken_limit = bne_hits + 1;
        push(8'd0, ADDI1); push(8'd1, enc_bne(12'hFFC)); push(8'hFF, ADDI2);
        push(8'd0, ADDI1); push(8'd1, enc_bne(12'hFFC)); push(8'd2, WFI);
        start();
        wait_done("t4_done", 40);
        check("t4_icnt", instr_count, 32'd6);
        check("t4_pc", 32'(pc), 32'd2);
        check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // 5: vec_done in the same ISSUE cycle as the vector op skips VWAIT.
        imem[0] = VMACC; imem[1] = WFI;
        push(8'd0, VMACC); push(8'd1, WFI);
        start();
        @(negedge clk);                                   // cycle 2: ISSUE vmacc
        vec_done = 1'b1; #1;
        check("t5_same_en", 32'(imem_en), 32'd1);
        check("t5_same_addr", 32'(imem_addr), 32'd1);
        @(negedge clk); vec_done = 1'b0;                  // cycle 3: FETCH
        check("t5_fetch_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);                                   // cycle 4: ISSUE wfi
        check("t5_valid_c4", 32'(instr_valid), 32'd1);
        wait_done("t5_done", 10);
        check("t5_scnt", stall_count, 32'd0);
        check("t5_icnt", instr_count, 32'd2);
        check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        // 6: reset while stalled in VWAIT.
        imem[0] = VMACC; imem[1] = WFI;
        push(8'd0, VMACC);
        start();
        repeat (3) @(negedge clk);                        // cycle 4: VWAIT
        check("t6_pre_scnt", stall_count, 32'd1);
        check("t6_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_pc", 32'(pc), 32'd0);
        check("t6_icnt", instr_count, 32'd0);
        check("t6_scnt", stall_count, 32'd0);
        check("t6_instr", instr, NOP);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("t6_no_done_%0d", c), 32'(ap_done), 32'd0);
            check($sformatf("t6_idle_%0d", c), 32'(busy | instr_valid), 32'd0);
        end
        check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
